// File: rtl/dpram_fifo_ctrl_if.sv
// Handshake/status bundle between a FIFO user and dpram_fifo_ctrl.
// Optional almost_full/almost_empty members exist only with DPRAM_FIFO_CTRL_STATUS_EN.
interface dpram_fifo_ctrl_if #(
   parameter int addr_width = 10
);
   logic                  wr_req;
   logic                  rd_req;
   logic                  ram_we;
   logic [addr_width-1:0] ram_wr_add;
   logic [addr_width-1:0] ram_rd_add;
   logic                  full;
   logic                  empty;
   logic                  rd_valid;
   logic [addr_width:0]   count;
   logic                  overflow;
   logic                  underflow;
`ifdef DPRAM_FIFO_CTRL_STATUS_EN
   logic                  almost_full;
   logic                  almost_empty;
`endif

   modport slave (
      input  wr_req, rd_req,
`ifdef DPRAM_FIFO_CTRL_STATUS_EN
      output almost_full, almost_empty,
`endif
      output ram_we, ram_wr_add, ram_rd_add, full, empty, rd_valid,
             count, overflow, underflow
   );

   modport master (
      output wr_req, rd_req,
`ifdef DPRAM_FIFO_CTRL_STATUS_EN
      input  almost_full, almost_empty,
`endif
      input  ram_we, ram_wr_add, ram_rd_add, full, empty, rd_valid,
             count, overflow, underflow
   );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// Pointer/flag/handshake controller turning a 1-cycle-latency dual-port RAM into a FIFO.
// Define DPRAM_FIFO_CTRL_STATUS_EN to add registered almost_full/almost_empty outputs.
module dpram_fifo_ctrl #(
   parameter int addr_width = 10,
   parameter int af_level   = 2**addr_width - 2,
   parameter int ae_level   = 2
) (
   input  logic            clk,
   input  logic            reset,
   dpram_fifo_ctrl_if.slave bus
);
   localparam int PtrW = addr_width + 1;
   localparam logic [PtrW-1:0] One = {{addr_width{1'b0}}, 1'b1};

   if (af_level < 0 || af_level > 2**addr_width ||
       ae_level < 0 || ae_level > 2**addr_width) begin : g_level_check
      $error("dpram_fifo_ctrl: af_level/ae_level outside 0..2**addr_width");
   end

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] count_q, count_d;
   logic            full_q, full_d;
   logic            empty_q, empty_d;
   logic            rd_valid_q;
   logic            overflow_q, overflow_d;
   logic            underflow_q, underflow_d;
   logic            wr_ok, rd_ok;

   // Acceptance is judged only against flags registered at the start of the cycle.
   always_comb begin
      wr_ok       = bus.wr_req & ~full_q;
      rd_ok       = bus.rd_req & ~empty_q;
      wr_ptr_d    = wr_ok ? wr_ptr_q + One : wr_ptr_q;
      rd_ptr_d    = rd_ok ? rd_ptr_q + One : rd_ptr_q;
      count_d     = count_q;
      if (wr_ok && !rd_ok) begin
         count_d = count_q + One;
      end else if (rd_ok && !wr_ok) begin
         count_d = count_q - One;
      end
      full_d      = (wr_ptr_d[addr_width-1:0] == rd_ptr_d[addr_width-1:0]) &&
                    (wr_ptr_d[addr_width] != rd_ptr_d[addr_width]);
      empty_d     = (wr_ptr_d == rd_ptr_d);
      overflow_d  = overflow_q  | (bus.wr_req & full_q);
      underflow_d = underflow_q | (bus.rd_req & empty_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         rd_valid_q  <= rd_ok;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

`ifdef DPRAM_FIFO_CTRL_STATUS_EN
   logic almost_full_q, almost_full_d;
   logic almost_empty_q, almost_empty_d;

   always_comb begin
      almost_full_d  = (count_d >= PtrW'(af_level));
      almost_empty_d = (count_d <= PtrW'(ae_level));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
      end else begin
         almost_full_q  <= almost_full_d;
         almost_empty_q <= almost_empty_d;
      end
   end

   assign bus.almost_full  = almost_full_q;
   assign bus.almost_empty = almost_empty_q;
`endif

   // RAM addresses follow the pointers directly; the RAM read register supplies the latency.
   assign bus.ram_we     = wr_ok;
   assign bus.ram_wr_add = wr_ptr_q[addr_width-1:0];
   assign bus.ram_rd_add = rd_ptr_q[addr_width-1:0];
   assign bus.full       = full_q;
   assign bus.empty      = empty_q;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.count      = count_q;
   assign bus.overflow   = overflow_q;
   assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl (addr_width=3) with a behavioural 1-cycle-latency RAM
// and a data scoreboard; honours DPRAM_FIFO_CTRL_STATUS_EN when defined.
module tb_dpram_fifo_ctrl;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] ram_d;
   logic [7:0] ram_q;
   logic [7:0] mem [DEPTH];

   dpram_fifo_ctrl_if #(.addr_width(AW)) bus ();
   dpram_fifo_ctrl #(.addr_width(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_wr_add] <= ram_d;
      ram_q <= mem[bus.ram_rd_add];
   end

   typedef struct {
      logic       wr;
      logic       rd;
      logic [7:0] dat;
      logic       exp_we;
      int         exp_count;
      logic       exp_full;
      logic       exp_empty;
      logic       exp_ovf;
      logic       exp_udf;
   } vec_t;

   vec_t       vecs [18];
   int         n_chk  = 0;
   int         n_fail = 0;
   int         m_count;
   logic [AW:0] m_wp, m_rp;
   logic       m_valid, m_ovf, m_udf;
   logic [7:0] sb [$];
   logic       we;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_count = 0; m_wp = '0; m_rp = '0;
      m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      sb.delete();
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_count"}, bus.count, 0);
      chk({tag, "_empty"}, bus.empty, 1);
      chk({tag, "_full"}, bus.full, 0);
      chk({tag, "_rd_valid"}, bus.rd_valid, 0);
      chk({tag, "_overflow"}, bus.overflow, 0);
      chk({tag, "_underflow"}, bus.underflow, 0);
      chk({tag, "_ram_we"}, bus.ram_we, 0);
      chk({tag, "_wr_add"}, bus.ram_wr_add, 0);
      chk({tag, "_rd_add"}, bus.ram_rd_add, 0);
`ifdef DPRAM_FIFO_CTRL_STATUS_EN
      chk({tag, "_almost_full"}, bus.almost_full, 0);
      chk({tag, "_almost_empty"}, bus.almost_empty, 1);
`endif
   endtask

   task automatic check_state();
      logic [7:0] exp_q;
      chk("count", bus.count, m_count);
      chk("full", bus.full, m_count == DEPTH);
      chk("empty", bus.empty, m_count == 0);
      chk("rd_valid", bus.rd_valid, m_valid);
      chk("overflow", bus.overflow, m_ovf);
      chk("underflow", bus.underflow, m_udf);
`ifdef DPRAM_FIFO_CTRL_STATUS_EN
      chk("almost_full", bus.almost_full, m_count >= 6);
      chk("almost_empty", bus.almost_empty, m_count <= 2);
`endif
      if (m_valid) begin
         if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
         end else begin
            exp_q = sb.pop_front();
            chk("q", ram_q, exp_q);
         end
      end
   endtask

   // One clock: drive at negedge, check combinational RAM controls, then registered state.
   task automatic step(input logic wr, input logic rd, input logic [7:0] dat, output logic we_seen);
      logic wr_ok, rd_ok;
      @(negedge clk);
      bus.wr_req = wr;
      bus.rd_req = rd;
      ram_d      = dat;
      #1;
      wr_ok   = wr && (m_count != DEPTH);
      rd_ok   = rd && (m_count != 0);
      we_seen = bus.ram_we;
      chk("ram_we", bus.ram_we, wr_ok);
      chk("ram_wr_add", bus.ram_wr_add, m_wp[AW-1:0]);
      chk("ram_rd_add", bus.ram_rd_add, m_rp[AW-1:0]);
      if (wr && !wr_ok) m_ovf = 1'b1;
      if (rd && !rd_ok) m_udf = 1'b1;
      if (wr_ok) begin
         sb.push_back(dat);
         m_wp = m_wp + 4'd1;
      end
      if (rd_ok) m_rp = m_rp + 4'd1;
      m_count = m_count + int'(wr_ok) - int'(rd_ok);
      m_valid = rd_ok;
      @(posedge clk);
      #1;
      check_state();
   endtask

   initial begin
      for (int i = 0; i < 8; i++)
         vecs[i] = '{1'b1, 1'b0, 8'(17 * (i + 1)), 1'b1, i + 1, (i == 7), 1'b0, 1'b0, 1'b0};
      vecs[8] = '{1'b1, 1'b0, 8'h99, 1'b0, 8, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 9; i < 17; i++)
         vecs[i] = '{1'b0, 1'b1, 8'h00, 1'b0, 16 - i, 1'b0, (i == 16), 1'b1, 1'b0};
      vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0};

      reset      = 1'b1;
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      ram_d      = 8'h00;
      model_clear();
      @(posedge clk);
      #1;
      check_reset_vals("rst_hold");
      @(negedge clk);
      reset = 1'b0;
      step(1'b0, 1'b0, 8'h00, we);
      check_reset_vals("idle");

      // Fill past full, then drain in order.
      for (int i = 0; i < 18; i++) begin
         step(vecs[i].wr, vecs[i].rd, vecs[i].dat, we);
         chk($sformatf("tbl%0d_we", i), we, vecs[i].exp_we);
         chk($sformatf("tbl%0d_count", i), bus.count, vecs[i].exp_count);
         chk($sformatf("tbl%0d_full", i), bus.full, vecs[i].exp_full);
         chk($sformatf("tbl%0d_empty", i), bus.empty, vecs[i].exp_empty);
         chk($sformatf("tbl%0d_ovf", i), bus.overflow, vecs[i].exp_ovf);
         chk($sformatf("tbl%0d_udf", i), bus.underflow, vecs[i].exp_udf);
      end

      // Write into empty FIFO with read held high.
      step(1'b1, 1'b1, 8'hA5, we);
      chk("t3_we", we, 1);
      chk("t3_udf", bus.underflow, 1);
      chk("t3_count0", bus.count, 1);
      chk("t3_rv0", bus.rd_valid, 0);
      step(1'b0, 1'b1, 8'h00, we);
      chk("t3_count1", bus.count, 0);
      chk("t3_rv1", bus.rd_valid, 1);
      chk("t3_q", ram_q, 8'hA5);
      step(1'b0, 1'b0, 8'h00, we);

      // Steady state at occupancy 4 with simultaneous traffic wrapping the pointers.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h20 + i), we);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b1, 8'($urandom_range(0, 255)), we);
         chk("t4_count", bus.count, 4);
      end
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, we);
      step(1'b0, 1'b0, 8'h00, we);
      chk("t4_empty", bus.empty, 1);

      // Full FIFO with simultaneous requests: read wins.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h30 + i), we);
      chk("t5_full", bus.full, 1);
      step(1'b1, 1'b1, 8'hEE, we);
      chk("t5_we", we, 0);
      chk("t5_count", bus.count, 7);
      chk("t5_full_after", bus.full, 0);
      chk("t5_ovf", bus.overflow, 1);
      step(1'b0, 1'b1, 8'h00, we);
      step(1'b0, 1'b1, 8'h00, we);
      chk("t6_count5", bus.count, 5);
      chk("t6_rv", bus.rd_valid, 1);

      // Asynchronous reset mid-operation.
      reset = 1'b1;
      bus.rd_req = 1'b0;
      #1;
      check_reset_vals("async_rst");
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      step(1'b0, 1'b0, 8'h00, we);
      check_reset_vals("post_rst");
      step(1'b1, 1'b0, 8'h5A, we);
      step(1'b0, 1'b1, 8'h00, we);
      chk("post_rst_q", ram_q, 8'h5A);
      step(1'b0, 1'b0, 8'h00, we);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
